cps1_rgbf_expander: RTL and testbench



---
 rtl/cps1_video_pkg.sv | 31 +++
 rtl/cps1_bright_rom.sv | 13 +
 rtl/cps1_rgbf_expander.sv | 88 ++++++++
 tb/tb_cps1_rgbf_expander.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cps1_video_pkg.sv
// cps1_video_pkg: brightness-law constants, side-band bundle and ROM/scanline helpers for the CPS1 video path
package cps1_video_pkg;
  localparam int BRIGHT_BASE = 15;
  localparam int BRIGHT_STEP = 2;
  localparam int BRIGHT_DIV = 45;
  localparam int RGBF_LATENCY = 3;
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic [8:0] x;
    logic [8:0] y;
    logic fc;
  } side_t;
  localparam side_t SIDE_RST = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: 9'd0, y: 9'd0, fc: 1'b0};
  // Entry {F,c} holds floor(c*17*(15+2F)/45), packed 8 bits per entry
  function automatic logic [2047:0] gen_bright_rom();
    logic [2047:0] t;
    t = '0;
    for (int f = 0; f < 16; f++)
      for (int c = 0; c < 16; c++)
        t[(f*16+c)*8 +: 8] = 8'((c * 17 * (BRIGHT_BASE + BRIGHT_STEP * f)) / BRIGHT_DIV);
    return t;
  endfunction
  // (4*c8 - str*c8) >> 2 keeps the fractional part until the final shift
  function automatic logic [7:0] scan_atten(input logic [7:0] c8, input logic [1:0] str);
    logic [9:0] m;
    m = (str[1] ? {1'b0, c8, 1'b0} : 10'd0) + (str[0] ? {2'b00, c8} : 10'd0);
    return 8'(({c8, 2'b00} - m) >> 2);
  endfunction
endpackage

// File: rtl/cps1_bright_rom.sv
// cps1_bright_rom: 256x8 brightness lookup indexed {F, c} with registered output
module cps1_bright_rom
  import cps1_video_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] f,
  input  logic [3:0] c,
  output logic [7:0] q
);
  localparam logic [2047:0] ROM = gen_bright_rom();
  always_ff @(posedge clk) q <= rst ? 8'd0 : ROM[{f, c, 3'b000} +: 8];
endmodule

// File: rtl/cps1_rgbf_expander.sv
// cps1_rgbf_expander: RGBF nibbles to RGB888 with 3-cycle aligned side-band; CPS1_SCANLINES_EN adds scanline darkening
module cps1_rgbf_expander
  import cps1_video_pkg::*;
(
  input  logic       PCLK2x_i,
  input  logic       reset_i,
  input  logic [3:0] R_i,
  input  logic [3:0] G_i,
  input  logic [3:0] B_i,
  input  logic [3:0] F_i,
  input  logic       HSYNC_i,
  input  logic       VSYNC_i,
  input  logic       DE_i,
  input  logic [8:0] xpos_i,
  input  logic [8:0] ypos_i,
  input  logic       frame_change_i,
`ifdef CPS1_SCANLINES_EN
  input  logic       scanline_en_i,
  input  logic [1:0] scanline_str_i,
`endif
  output logic [7:0] R_o,
  output logic [7:0] G_o,
  output logic [7:0] B_o,
  output logic       HSYNC_o,
  output logic       VSYNC_o,
  output logic       DE_o,
  output logic [8:0] xpos_o,
  output logic [8:0] ypos_o,
  output logic       frame_change_o
);
  side_t s1, s2, s3;
  logic [3:0] r1, g1, b1, f1;
  logic [7:0] r2, g2, b2, r3, g3, b3;
  logic parity;
  always_ff @(posedge PCLK2x_i) begin
    if (reset_i) begin
      s1 <= SIDE_RST;
      s2 <= SIDE_RST;
      s3 <= SIDE_RST;
      {r1, g1, b1, f1} <= '0;
    end else begin
      s1 <= '{hs: HSYNC_i, vs: VSYNC_i, de: DE_i, x: xpos_i, y: ypos_i, fc: frame_change_i};
      s2 <= s1;
      s3 <= s2;
      {r1, g1, b1, f1} <= {R_i, G_i, B_i, F_i};
    end
  end
  // Edges seen between S1 and S2 so the last pixel of a line still leaves with the old parity
  always_ff @(posedge PCLK2x_i)
    parity <= (reset_i || (s2.vs && !s1.vs)) ? 1'b0 : (s2.de && !s1.de) ? ~parity : parity;
  cps1_bright_rom u_rom_r (.clk(PCLK2x_i), .rst(reset_i), .f(f1), .c(r1), .q(r2));
  cps1_bright_rom u_rom_g (.clk(PCLK2x_i), .rst(reset_i), .f(f1), .c(g1), .q(g2));
  cps1_bright_rom u_rom_b (.clk(PCLK2x_i), .rst(reset_i), .f(f1), .c(b1), .q(b2));
`ifdef CPS1_SCANLINES_EN
  logic en1, en2;
  logic [1:0] st1, st2;
  always_ff @(posedge PCLK2x_i) begin
    if (reset_i) begin
      {en1, en2, st1, st2} <= '0;
    end else begin
      {en1, st1} <= {scanline_en_i, scanline_str_i};
      {en2, st2} <= {en1, st1};
    end
  end
  always_comb begin
    r3 = (en2 && parity) ? scan_atten(r2, st2) : r2;
    g3 = (en2 && parity) ? scan_atten(g2, st2) : g2;
    b3 = (en2 && parity) ? scan_atten(b2, st2) : b2;
  end
`else
  always_comb begin
    r3 = r2;
    g3 = g2;
    b3 = b2;
  end
`endif
  always_ff @(posedge PCLK2x_i) begin
    R_o <= (reset_i || !s2.de) ? 8'd0 : r3;
    G_o <= (reset_i || !s2.de) ? 8'd0 : g3;
    B_o <= (reset_i || !s2.de) ? 8'd0 : b3;
  end
  assign HSYNC_o = s3.hs;
  assign VSYNC_o = s3.vs;
  assign DE_o = s3.de;
  assign xpos_o = s3.x;
  assign ypos_o = s3.y;
  assign frame_change_o = s3.fc;
endmodule

// File: tb/tb_cps1_rgbf_expander.sv
// tb_cps1_rgbf_expander: scoreboard bench for the RGBF expander; scanline scenario built with CPS1_SCANLINES_EN
module tb_cps1_rgbf_expander;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic hs;
    logic vs;
    logic de;
    logic [8:0] x;
    logic [8:0] y;
    logic fc;
  } out_t;
  localparam out_t ORST = {8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 9'd0, 9'd0, 1'b0};
  logic clk = 0, rst = 1;
  logic [3:0] r_i = 0, g_i = 0, b_i = 0, f_i = 0;
  logic hs_i = 1, vs_i = 1, de_i = 0, fc_i = 0;
  logic [8:0] x_i = 0, y_i = 0;
  logic en = 0;
  logic [1:0] str = 0;
  logic [7:0] r_o, g_o, b_o;
  logic hs_o, vs_o, de_o, fc_o;
  logic [8:0] x_o, y_o;
  out_t got;
  out_t q[$];
  int n_cmp = 0, n_bad = 0;
  string tname = "init";
  logic p_de = 0, p_vs = 1, par = 0;
  always #5 clk = ~clk;
  cps1_rgbf_expander dut (
    .PCLK2x_i(clk), .reset_i(rst),
    .R_i(r_i), .G_i(g_i), .B_i(b_i), .F_i(f_i),
    .HSYNC_i(hs_i), .VSYNC_i(vs_i), .DE_i(de_i),
    .xpos_i(x_i), .ypos_i(y_i), .frame_change_i(fc_i),
`ifdef CPS1_SCANLINES_EN
    .scanline_en_i(en), .scanline_str_i(str),
`endif
    .R_o(r_o), .G_o(g_o), .B_o(b_o),
    .HSYNC_o(hs_o), .VSYNC_o(vs_o), .DE_o(de_o),
    .xpos_o(x_o), .ypos_o(y_o), .frame_change_o(fc_o)
  );
  assign got = {r_o, g_o, b_o, hs_o, vs_o, de_o, x_o, y_o, fc_o};
  function automatic logic [7:0] expc(input int c, input int f, input logic dim, input int s);
    int v;
    v = (c * 17 * (15 + 2 * f)) / 45;
    if (dim) v = (v * (4 - s)) / 4;
    return 8'(v);
  endfunction
  task automatic step(input logic [3:0] r, g, b, f, input logic hs, vs, de,
                      input logic [8:0] x, y, input logic fc, input logic rs);
    out_t e;
    @(negedge clk);
    {r_i, g_i, b_i, f_i, hs_i, vs_i, de_i, x_i, y_i, fc_i, rst} = {r, g, b, f, hs, vs, de, x, y, fc, rs};
    if (rs) begin
      p_de = 0; p_vs = 1; par = 0;
    end else begin
      if (p_vs && !vs) par = 0;
      else if (p_de && !de) par = ~par;
      p_de = de; p_vs = vs;
    end
    e.r = de ? expc(r, f, en && par, str) : 8'd0;
    e.g = de ? expc(g, f, en && par, str) : 8'd0;
    e.b = de ? expc(b, f, en && par, str) : 8'd0;
    {e.hs, e.vs, e.de, e.x, e.y, e.fc} = {hs, vs, de, x, y, fc};
    q.push_back(e);
  endtask
  always begin : monitor
    out_t e;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      n_cmp++;
      if (got !== ORST) begin
        n_bad++;
        $display("FAIL %s reset_out: got %h expected %h", tname, got, ORST);
      end
      q.push_back(ORST);
      q.push_back(ORST);
    end else if (q.size() >= 3) begin
      e = q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s pixel: got %h expected %h", tname, got, e);
      end
    end
  end
  task automatic drain();
    repeat (4) step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic test_reset();
    tname = "reset";
    repeat (4) step(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 9'($urandom), 9'($urandom), 1'($urandom), 1);
    @(posedge clk);
    #2;
    n_cmp++;
    if ({r_o, g_o, b_o, de_o, hs_o, vs_o, fc_o} !== {24'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_hold: got %h expected %h", {r_o, g_o, b_o, de_o, hs_o, vs_o, fc_o}, {24'd0, 4'b0110});
    end
  endtask
  task automatic test_exhaustive();
    tname = "exhaustive";
    for (int f = 0; f < 16; f++)
      for (int c = 0; c < 16; c++)
        step(4'(c), 4'(15 - c), 4'(c), 4'(f), 1, 1, 1, 9'(c + 16 * f), 9'(f), 0, 0);
    drain();
  endtask
  task automatic test_alignment();
    tname = "alignment";
    for (int i = 0; i < 12; i++)
      step(4'(i), 4'(i), 4'(15 - i), 15, i != 3, 1, i == 5, (i < 6) ? 9'd10 : 9'd200, 9'd7, i == 7, 0);
    drain();
  endtask
  task automatic test_blanking();
    tname = "blanking";
    repeat (6) step(15, 15, 15, 15, 1, 1, 0, 9'd3, 9'd4, 0, 0);
    drain();
  endtask
`ifdef CPS1_SCANLINES_EN
  task automatic test_scanlines();
    tname = "scanlines";
    en = 1;
    str = 2;
    drain();
    for (int l = 0; l < 2; l++) begin
      repeat (6) step(15, 15, 15, 15, 1, 1, 1, 9'd1, 9'(l), 0, 0);
      repeat (3) step(15, 15, 15, 15, 0, 1, 0, 9'd0, 9'(l), 0, 0);
    end
    repeat (2) step(0, 0, 0, 0, 1, 0, 0, 9'd0, 9'd0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 1, 1, 0, 9'd0, 9'd0, 0, 0);
    repeat (6) step(15, 15, 15, 15, 1, 1, 1, 9'd1, 9'd0, 0, 0);
    repeat (3) step(15, 15, 15, 15, 0, 1, 0, 9'd0, 9'd0, 0, 0);
    repeat (6) step(15, 15, 15, 15, 1, 1, 1, 9'd1, 9'd1, 0, 0);
    drain();
    en = 0;
    drain();
  endtask
`endif
  task automatic test_midline_reset();
    tname = "midline_reset";
    for (int i = 0; i < 5; i++) step(4'(i + 5), 9, 12, 10, 1, 1, 1, 9'(i), 9'd20, 0, 0);
    step(15, 15, 15, 15, 1, 1, 1, 9'd5, 9'd20, 0, 1);
    @(posedge clk);
    #2;
    n_cmp++;
    if ({r_o, de_o, x_o} !== {8'd0, 1'b0, 9'd0}) begin
      n_bad++;
      $display("FAIL midline_reset_edge: got %h expected %h", {r_o, de_o, x_o}, 18'd0);
    end
    for (int i = 0; i < 6; i++) step(4'(i + 2), 4'(i), 7, 4'(i * 2), 1, 1, 1, 9'(i + 6), 9'd20, 0, 0);
    drain();
  endtask
  initial begin
    test_reset();
    test_exhaustive();
    test_alignment();
    test_blanking();
`ifdef CPS1_SCANLINES_EN
    test_scanlines();
`endif
    test_midline_reset();
    test_back_to_back();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  task automatic test_back_to_back();
    tname = "back_to_back";
    for (int i = 0; i < 40; i++)
      step(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 9'($urandom), 9'($urandom), 1'($urandom), 0);
    drain();
  endtask
endmodule
